// File: rtl/apb_fifo_slave.sv
// APB responder fronting a DEPTH-entry 32-bit FIFO.
// Registers (word-mapped on PADDR[3:2]): CTRL, STATUS, PUSH, POP.
// Every transfer passes through a small FSM that inserts WAIT_STATES
// cycles of PREADY=0 in the ACCESS phase before completing.
module apb_fifo_slave #(
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);   // pointer width
    localparam int CW = AW + 1;          // count width, holds 0..DEPTH

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_PUSH   = 2'd2,
        REG_POP    = 2'd3
    } reg_t;

    // Transfer FSM
    state_t       state;
    state_t       state_nxt;
    logic [2:0]   wcnt;
    logic [2:0]   wcnt_nxt;
    reg_t         addr_q;
    logic         write_q;

    // FIFO and register state
    logic [31:0]  ram [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic         ie;
    logic         ovf;
    logic         udf;

    logic         setup;
    logic         access;
    logic         full;
    logic         empty;
    logic         do_write;
    logic         do_read;
    logic         push;
    logic         pop;
    logic [31:0]  status_word;

    // Address bits outside the word decode are intentionally ignored.
    logic         unused_addr;
    assign unused_addr = ^{PADDR[31:4], PADDR[1:0]};

    assign setup  = PSEL & ~PENABLE;
    assign access = PSEL & PENABLE;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);

    // A transfer commits on the single cycle PREADY is high.
    assign do_write = PREADY & write_q;
    assign do_read  = PREADY & ~write_q;
    assign push     = do_write & (addr_q == REG_PUSH);
    assign pop      = do_read  & (addr_q == REG_POP);

    // State register; also captures the decoded address and direction at SETUP.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples the pre-edge values of the others.
        if (!PRESET) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            addr_q  <= REG_CTRL;
            write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (state == S_IDLE && setup) begin
                addr_q  <= reg_t'(PADDR[3:2]);
                write_q <= PWRITE;
            end
        end
    end

    // Next-state logic: SETUP loads the wait counter, WAIT counts it down,
    // DONE always returns to IDLE; losing PSEL/PENABLE aborts the transfer.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_IDLE: begin
                if (setup) begin
                    wcnt_nxt  = 3'(WAIT_STATES);
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (!access) begin
                    state_nxt = S_IDLE;
                end else begin
                    wcnt_nxt = wcnt - 3'd1;
                    if (wcnt <= 3'd1) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // STATUS register image: {count, udf, ovf, full, empty}.
    always_comb begin
        status_word           = '0;
        status_word[0]        = empty;
        status_word[1]        = full;
        status_word[2]        = ovf;
        status_word[3]        = udf;
        status_word[4 +: CW]  = count;
    end

    // Outputs: PREADY only in DONE with the master still in ACCESS;
    // PRDATA is the register mux, forced to 0 whenever PREADY is low.
    always_comb begin
        PREADY = (state == S_DONE) & access;
        PRDATA = '0;
        if (PREADY && !write_q) begin
            case (addr_q)
                REG_CTRL:   PRDATA = {31'd0, ie};
                REG_STATUS: PRDATA = status_word;
                REG_PUSH:   PRDATA = '0;
                REG_POP:    PRDATA = empty ? 32'd0 : ram[rd_ptr];
                default:    PRDATA = '0;
            endcase
        end
    end

    // FIFO storage; written only on an accepted push.
    always_ff @(posedge PCLK) begin
        // NOTE: the RAM is deliberately not reset; pointers and count define
        // which entries are valid, so stale content is never observable.
        if (push && !full) begin
            ram[wr_ptr] <= PWDATA;
        end
    end

    // Register side effects at the commit edge, plus the registered interrupt.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ie     <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq <= ie & (~empty | ovf);

            if (do_write && addr_q == REG_CTRL) begin
                ie <= PWDATA[0];
                if (PWDATA[1]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end
            end

            if (do_write && addr_q == REG_STATUS) begin
                if (PWDATA[2]) ovf <= 1'b0;
                if (PWDATA[3]) udf <= 1'b0;
            end

            if (push) begin
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + AW'(1);
                    count  <= count + CW'(1);
                end
            end

            if (pop) begin
                if (empty) begin
                    udf <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + AW'(1);
                    count  <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Self-checking bench for apb_fifo_slave (DEPTH=8, WAIT_STATES=3).
// A table of APB transfers with hand-computed read data, then directed
// sequences for ordering/wrap, interrupt timing and protocol aborts.
module tb_apb_fifo_slave;

    localparam int DEPTH = 8;
    localparam int WS    = 3;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_PUSH   = 32'h8;
    localparam logic [31:0] A_POP    = 32'hC;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;

    int tests  = 0;
    int failed = 0;

    apb_fifo_slave #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] paddr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;    // expected PRDATA for reads
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full APB transfer. Inputs change 1 time unit after a rising edge;
    // lat is the ACCESS cycle (1-based) where PREADY was seen, early is
    // PRDATA on the first ACCESS cycle.
    task automatic apb_xfer(input logic [31:0] paddr, input logic wr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic [31:0] early, output int lat);
        @(posedge PCLK); #1;
        PADDR   = paddr;
        PWRITE  = wr;
        PWDATA  = wdata;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lat     = 1;
        early   = PRDATA;
        while (!PREADY && lat < 20) begin
            @(posedge PCLK); #1;
            lat++;
        end
        rdata = PRDATA;
        if (!PREADY) begin
            check("pready timeout", {31'd0, PREADY}, 32'd1);
            lat = -1;
        end
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] paddr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic [31:0] er;
        int          lat;
        apb_xfer(paddr, 1'b1, wdata, rd, er, lat);
    endtask

    task automatic apb_read_check(input string name, input logic [31:0] paddr, input logic [31:0] exp);
        logic [31:0] rd;
        logic [31:0] er;
        int          lat;
        apb_xfer(paddr, 1'b0, 32'd0, rd, er, lat);
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] er;
        int          lat;
        logic        seen_ready;

        // Transfer table: {paddr, write, wdata, expected read data}
        vecs[0]  = '{A_STATUS, 1'b0, 32'h0,         32'h0000_0001}; // empty after reset
        vecs[1]  = '{A_PUSH,   1'b1, 32'hDEAD_BEEF, 32'h0};
        vecs[2]  = '{A_STATUS, 1'b0, 32'h0,         32'h0000_0010}; // count=1
        vecs[3]  = '{A_POP,    1'b0, 32'h0,         32'hDEAD_BEEF};
        vecs[4]  = '{A_STATUS, 1'b0, 32'h0,         32'h0000_0001};
        vecs[5]  = '{A_POP,    1'b0, 32'h0,         32'h0000_0000}; // underflow
        vecs[6]  = '{A_STATUS, 1'b0, 32'h0,         32'h0000_0009}; // udf|empty
        vecs[7]  = '{A_STATUS, 1'b1, 32'h8,         32'h0};         // W1C udf
        vecs[8]  = '{A_STATUS, 1'b0, 32'h0,         32'h0000_0001};
        vecs[9]  = '{A_CTRL,   1'b0, 32'h0,         32'h0000_0000};
        vecs[10] = '{A_PUSH,   1'b0, 32'h0,         32'h0000_0000}; // PUSH reads 0
        vecs[11] = '{A_POP,    1'b1, 32'h123,       32'h0};         // ignored
        vecs[12] = '{32'h7,    1'b0, 32'h0,         32'h0000_0001}; // low addr bits ignored

        PRESET  = 1'b0;
        PADDR   = '0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PWDATA  = '0;

        // Reset held for two edges
        repeat (2) @(posedge PCLK);
        #1;
        check("reset PREADY", {31'd0, PREADY}, 32'd0);
        check("reset PRDATA", PRDATA, 32'd0);
        check("reset irq",    {31'd0, irq},    32'd0);
        PRESET = 1'b1;

        // Table-driven transfers
        for (int i = 0; i < 13; i++) begin
            apb_xfer(vecs[i].paddr, vecs[i].wr, vecs[i].wdata, rd, er, lat);
            check($sformatf("vec%0d latency", i), lat, WS + 1);
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
                check($sformatf("vec%0d early rdata", i), er, 32'd0);
            end
        end

        // Order, overflow and pointer wrap
        for (int i = 0; i < 12; i++) apb_write(A_PUSH, i);
        apb_read_check("status after overfill", A_STATUS, 32'h0000_0086);
        for (int i = 0; i < 8; i++) apb_read_check($sformatf("pop order %0d", i), A_POP, i);
        apb_read_check("status drained ovf", A_STATUS, 32'h0000_0005);
        apb_write(A_STATUS, 32'h4);
        apb_read_check("status ovf cleared", A_STATUS, 32'h0000_0001);
        for (int i = 0; i < 8; i++) apb_write(A_PUSH, 32'd100 + i);
        apb_read_check("status full again", A_STATUS, 32'h0000_0082);
        for (int i = 0; i < 8; i++) apb_read_check($sformatf("pop wrap %0d", i), A_POP, 32'd100 + i);
        apb_read_check("status wrap empty", A_STATUS, 32'h0000_0001);

        // Interrupt: registered, one cycle behind the commit edge
        apb_write(A_CTRL, 32'h1);
        @(posedge PCLK); #1;
        check("irq ie only", {31'd0, irq}, 32'd0);
        apb_write(A_PUSH, 32'h5);
        check("irq at commit", {31'd0, irq}, 32'd0);
        @(posedge PCLK); #1;
        check("irq after commit", {31'd0, irq}, 32'd1);
        apb_write(A_CTRL, 32'h3);
        check("irq at flush commit", {31'd0, irq}, 32'd1);
        @(posedge PCLK); #1;
        check("irq after flush", {31'd0, irq}, 32'd0);
        apb_read_check("status after flush", A_STATUS, 32'h0000_0001);
        apb_read_check("ctrl after flush", A_CTRL, 32'h0000_0001);
        apb_write(A_CTRL, 32'h0);

        // PSEL dropped during WAIT: no push, PREADY never rises
        @(posedge PCLK); #1;
        PADDR = A_PUSH; PWRITE = 1'b1; PWDATA = 32'hAA; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        seen_ready = PREADY;
        @(posedge PCLK); #1;
        seen_ready |= PREADY;
        PSEL = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge PCLK); #1;
            seen_ready |= PREADY;
        end
        check("abort PREADY", {31'd0, seen_ready}, 32'd0);
        apb_read_check("abort no push", A_STATUS, 32'h0000_0001);

        // Reset asserted during WAIT
        apb_write(A_CTRL, 32'h1);
        apb_write(A_PUSH, 32'h77);
        apb_read_check("pre-reset count", A_STATUS, 32'h0000_0010);
        @(posedge PCLK); #1;
        PADDR = A_PUSH; PWRITE = 1'b1; PWDATA = 32'hBB; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        check("mid reset PREADY", {31'd0, PREADY}, 32'd0);
        check("mid reset irq",    {31'd0, irq},    32'd0);
        seen_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge PCLK); #1;
            seen_ready |= PREADY;
        end
        check("mid reset idle", {31'd0, seen_ready}, 32'd0);
        apb_read_check("mid reset empty", A_STATUS, 32'h0000_0001);
        apb_read_check("mid reset ctrl",  A_CTRL,   32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
